mdu_seq: RTL and testbench

- Iterative multiply/divide unit in the execute stage; sits directly upstream of the 8x16 register file.
- Consumes the two register-file read operands and produces a single writeback: rd, write_data and a one-cycle reg_write strobe into the register file.
- Holds one operation at a time and reports busy so the sequencer stalls issue.

---
 rtl/mdu_seq_if.sv | 28 ++
 rtl/mdu_seq.sv | 172 +++++++++++++++++
 tb/tb_mdu_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_if.sv
// Execute-stage handshake/writeback bundle between the issue sequencer and mdu_seq.
// master = sequencer side, slave = multiply/divide unit.
interface mdu_seq_if #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned REG_ADDR_W = 3
);
    logic                  start;
    logic [1:0]            op;
    logic [REG_ADDR_W-1:0] rd_in;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic                  busy;
    logic                  done;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
    logic [WIDTH-1:0]      write_data;
    logic                  div_zero;

    modport master (
        output start, op, rd_in, a, b,
        input  busy, done, reg_write, rd, write_data, div_zero
    );

    modport slave (
        input  start, op, rd_in, a, b,
        output busy, done, reg_write, rd, write_data, div_zero
    );
endinterface

// File: rtl/mdu_seq.sv
// Iterative unsigned multiply/divide unit (shift-add MUL/MULHU, restoring DIVU/REMU).
// Optional MDU_FAST_ZERO_EN: zero-operand / divide-by-zero cases bypass the iteration loop.
module mdu_seq #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned CNT_W      = 5
) (
    input logic       clk,
    input logic       rst_n,
    mdu_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    state_e state_q, state_nxt;

    op_e                   op_q;
    logic [REG_ADDR_W-1:0] rd_lat_q;
    logic [WIDTH-1:0]      b_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  dz_q;

    logic [2*WIDTH-1:0]    prod_q, prod_nxt;
    logic [WIDTH:0]        mul_sum;
    logic [WIDTH:0]        rem_q, rem_nxt, rem_shift;
    logic [WIDTH+1:0]      trial;
    logic                  borrow;
    logic [WIDTH-1:0]      quo_q, quo_nxt;

    logic [REG_ADDR_W-1:0] rd_out_q;
    logic [WIDTH-1:0]      wd_out_q;
    logic [WIDTH-1:0]      run_result;
    logic [WIDTH-1:0]      fast_result;
    logic                  fast_zero;
    logic                  last_iter;

`ifdef MDU_FAST_ZERO_EN
    assign fast_zero = bus.op[1] ? (bus.b == '0) : ((bus.a == '0) || (bus.b == '0));
`else
    assign fast_zero = 1'b0;
`endif

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = fast_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration of each algorithm. The multiplier sits in the low half of
    // prod_q and is consumed LSB first as the partial sum shifts in from the top.
    // For b==0 the trial subtraction never borrows, which naturally yields an
    // all-ones quotient and a remainder equal to the dividend.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? b_q : {WIDTH{1'b0}})};
        prod_nxt  = {mul_sum, prod_q[WIDTH-1:1]};
        rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial     = {1'b0, rem_shift} - {2'b00, b_q};
        borrow    = trial[WIDTH+1];
        rem_nxt   = borrow ? rem_shift : trial[WIDTH:0];
        quo_nxt   = {quo_q[WIDTH-2:0], ~borrow};
    end

    always_comb begin
        run_result = '0;
        case (op_q)
            OP_MUL:   run_result = prod_nxt[WIDTH-1:0];
            OP_MULHU: run_result = prod_nxt[2*WIDTH-1:WIDTH];
            OP_DIVU:  run_result = quo_nxt;
            OP_REMU:  run_result = rem_nxt[WIDTH-1:0];
            default:  run_result = '0;
        endcase
    end

    always_comb begin
        fast_result = '0;
        case (bus.op)
            2'b10:   fast_result = '1;
            2'b11:   fast_result = bus.a;
            default: fast_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_MUL;
            rd_lat_q <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            dz_q     <= 1'b0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            rd_out_q <= '0;
            wd_out_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q     <= op_e'(bus.op);
                        rd_lat_q <= bus.rd_in;
                        b_q      <= bus.b;
                        cnt_q    <= '0;
                        dz_q     <= bus.op[1] && (bus.b == '0);
                        prod_q   <= {{WIDTH{1'b0}}, bus.a};
                        rem_q    <= '0;
                        quo_q    <= bus.a;
                        if (fast_zero) begin
                            rd_out_q <= bus.rd_in;
                            wd_out_q <= fast_result;
                        end
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (op_q[1]) begin
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                    end else begin
                        prod_q <= prod_nxt;
                    end
                    if (last_iter) begin
                        rd_out_q <= rd_lat_q;
                        wd_out_q <= run_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.reg_write  = (state_q == DONE);
    assign bus.div_zero   = (state_q == DONE) && dz_q;
    assign bus.rd         = rd_out_q;
    assign bus.write_data = wd_out_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq; honours MDU_FAST_ZERO_EN for zero-case latency.
module tb_mdu_seq;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned FULL_LAT   = WIDTH + 1;
`ifdef MDU_FAST_ZERO_EN
    localparam int unsigned ZERO_LAT   = 1;
`else
    localparam int unsigned ZERO_LAT   = WIDTH + 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   wr_count = 0;

    mdu_seq_if #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) bus ();

    mdu_seq #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.reg_write) wr_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [2:0] rd,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_data, input logic exp_dz, input int exp_lat);
        int cyc;
        int wr_before;
        @(negedge clk);
        wr_before   = wr_count;
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rd_in   = rd;
        bus.a       = a;
        bus.b       = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 1;
        check({name, "/busy"}, 32'(bus.busy), 32'd1);
        while (!bus.done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, "/latency"}, 32'(cyc), 32'(exp_lat));
        check({name, "/reg_write"}, 32'(bus.reg_write), 32'd1);
        check({name, "/rd"}, 32'(bus.rd), 32'(rd));
        check({name, "/data"}, 32'(bus.write_data), 32'(exp_data));
        check({name, "/div_zero"}, 32'(bus.div_zero), 32'(exp_dz));
        @(posedge clk);
        #1;
        check({name, "/pulse_end"}, {30'd0, bus.done, bus.reg_write}, 32'd0);
        check({name, "/idle"}, 32'(bus.busy), 32'd0);
        check({name, "/hold"}, 32'(bus.write_data), 32'(exp_data));
        check({name, "/writes"}, 32'(wr_count - wr_before), 32'd1);
    endtask

    initial begin
        int cyc;
        int wr_before;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.rd_in = '0;
        bus.a     = '0;
        bus.b     = '0;

        #12;
        check("reset/outs", {25'd0, bus.busy, bus.done, bus.reg_write, bus.div_zero, bus.rd}, 32'd0);
        check("reset/data", 32'(bus.write_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul5x3",  2'b00, 3'd3, 16'h0005, 16'h0003, 16'h000F, 1'b0, FULL_LAT);
        run_op("mul_lo",  2'b00, 3'd1, 16'h1234, 16'h5678, 16'h0060, 1'b0, FULL_LAT);
        run_op("mulhu",   2'b01, 3'd2, 16'h1234, 16'h5678, 16'h0626, 1'b0, FULL_LAT);
        run_op("mulhu_ff",2'b01, 3'd6, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, FULL_LAT);
        run_op("divu",    2'b10, 3'd4, 16'd100,  16'd7,    16'h000E, 1'b0, FULL_LAT);
        run_op("remu",    2'b11, 3'd5, 16'd100,  16'd7,    16'h0002, 1'b0, FULL_LAT);
        run_op("divu_big",2'b10, 3'd0, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, FULL_LAT);
        run_op("divu_z",  2'b10, 3'd7, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, ZERO_LAT);
        run_op("remu_z",  2'b11, 3'd0, 16'h1234, 16'h0000, 16'h1234, 1'b1, ZERO_LAT);

        // start pulses while a MUL is running must not disturb it
        @(negedge clk);
        wr_before = wr_count;
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.rd_in = 3'd5;
        bus.a     = 16'h1234;
        bus.b     = 16'h5678;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            if (cyc == 5 || cyc == 16) begin
                bus.start = 1'b1;
                bus.op    = 2'b10;
                bus.rd_in = 3'd7;
                bus.a     = 16'hFFFF;
                bus.b     = 16'h0001;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        check("ign/latency", 32'(cyc), 32'(FULL_LAT));
        check("ign/rd", 32'(bus.rd), 32'd5);
        check("ign/data", 32'(bus.write_data), 32'h0060);
        repeat (4) @(posedge clk);
        #1;
        check("ign/writes", 32'(wr_count - wr_before), 32'd1);
        check("ign/idle", 32'(bus.busy), 32'd0);

        // asynchronous reset in the middle of a DIVU
        @(negedge clk);
        wr_before = wr_count;
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.rd_in = 3'd4;
        bus.a     = 16'd100;
        bus.b     = 16'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst/outs", {25'd0, bus.busy, bus.done, bus.reg_write, bus.div_zero, bus.rd}, 32'd0);
        check("arst/data", 32'(bus.write_data), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("arst/nowrite", 32'(wr_count - wr_before), 32'd0);
        check("arst/idle", 32'(bus.busy), 32'd0);

        run_op("mul2x2", 2'b00, 3'd2, 16'h0002, 16'h0002, 16'h0004, 1'b0, FULL_LAT);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
